countdown_timer_bcd: RTL and testbench

- Game-clock source for the 7-segment display path: a MM:SS countdown timer that decrements once per second.
- Presents four BCD digit nibbles. Each nibble feeds one 4-bit-to-7-segment decoder instance directly.
- Provides run/pause/reload control, a once-per-second tick pulse and an expiry flag for game-over logic.

---
 rtl/countdown_timer_bcd_pkg.sv | 22 ++
 rtl/countdown_timer_bcd_digit.sv | 28 ++
 rtl/countdown_timer_bcd.sv | 114 +++++++++++
 tb/tb_countdown_timer_bcd.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_bcd_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
package countdown_timer_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_e;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic [3:0] bcd_tens(input int unsigned v);
    return 4'(v / 10);
  endfunction

  function automatic logic [3:0] bcd_ones(input int unsigned v);
    return 4'(v % 10);
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// One BCD down-counting digit; wraps 0 -> MAX_VAL and forwards a borrow.
module bcd_down_digit #(
  parameter logic [3:0] MAX_VAL = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_q;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      digit_q <= load_val;
    end else if (dec_en && borrow_in) begin
      digit_q <= (digit_q == '0) ? MAX_VAL : digit_q - 4'd1;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = borrow_in && (digit_q == '0);

endmodule

// File: rtl/countdown_timer_bcd.sv
// MM:SS countdown timer with run/pause/reload control, 1 Hz tick pulse and expiry flag.
module countdown_timer_bcd #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned START_MIN     = 1,
  parameter int unsigned START_SEC     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       reload,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic       running,
  output logic       expired
);
  import countdown_timer_bcd_pkg::*;

  localparam int unsigned   PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic          sec_tick_q, running_q, expired_q;

  logic go, hold, tc, dec_en, last_sec;
  logic b_so, b_st, b_mo, all_zero;

  assign go   = start && !pause;
  assign hold = pause && !start;
  assign tc   = (presc_q == TC);

  // The borrow out of the top digit is high only at 00:00, so it doubles as the zero detector.
  assign dec_en   = (state_q == RUN) && !reload && !hold && tc && !all_zero;
  assign last_sec = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0) && (sec_ones == 4'd1);

  bcd_down_digit #(.MAX_VAL(DIGIT_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .load(reload), .load_val(bcd_ones(START_SEC)),
    .dec_en(dec_en), .borrow_in(1'b1), .digit(sec_ones), .borrow_out(b_so)
  );

  bcd_down_digit #(.MAX_VAL(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .load(reload), .load_val(bcd_tens(START_SEC)),
    .dec_en(dec_en), .borrow_in(b_so), .digit(sec_tens), .borrow_out(b_st)
  );

  bcd_down_digit #(.MAX_VAL(DIGIT_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .load(reload), .load_val(bcd_ones(START_MIN)),
    .dec_en(dec_en), .borrow_in(b_st), .digit(min_ones), .borrow_out(b_mo)
  );

  bcd_down_digit #(.MAX_VAL(DIGIT_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .load(reload), .load_val(bcd_tens(START_MIN)),
    .dec_en(dec_en), .borrow_in(b_mo), .digit(min_tens), .borrow_out(all_zero)
  );

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            presc_q <= '0;
            if (all_zero) begin
              state_q   <= EXPIRED;
              expired_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hold) begin
            state_q   <= PAUSED;
            running_q <= 1'b0;
          end else if (tc) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b1;
            if (last_sec) begin
              state_q   <= EXPIRED;
              running_q <= 1'b0;
              expired_q <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        PAUSED: begin
          if (go) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        EXPIRED: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sec_tick = sec_tick_q;
  assign running  = running_q;
  assign expired  = expired_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd: four parameterisations driven in lockstep against a seconds-level model.
module tb_countdown_timer_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, pause, reload;
  logic [3:0] mt[4], mo[4], st[4], so[4];
  logic       tk[4], rn[4], ex[4];

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
  int tps[4] = '{4, 4, 4, 2};
  int pre[4] = '{90, 2, 0, 5999};
  int m_secs[4] = '{90, 2, 0, 5999};
  int m_mode[4] = '{0, 0, 0, 0};
  int m_cnt[4]  = '{0, 0, 0, 0};
  bit m_tick[4] = '{0, 0, 0, 0};

  countdown_timer_bcd #(.TICKS_PER_SEC(4), .START_MIN(1), .START_SEC(30)) u0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .reload(reload),
    .min_tens(mt[0]), .min_ones(mo[0]), .sec_tens(st[0]), .sec_ones(so[0]),
    .sec_tick(tk[0]), .running(rn[0]), .expired(ex[0]));
  countdown_timer_bcd #(.TICKS_PER_SEC(4), .START_MIN(0), .START_SEC(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .reload(reload),
    .min_tens(mt[1]), .min_ones(mo[1]), .sec_tens(st[1]), .sec_ones(so[1]),
    .sec_tick(tk[1]), .running(rn[1]), .expired(ex[1]));
  countdown_timer_bcd #(.TICKS_PER_SEC(4), .START_MIN(0), .START_SEC(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .reload(reload),
    .min_tens(mt[2]), .min_ones(mo[2]), .sec_tens(st[2]), .sec_ones(so[2]),
    .sec_tick(tk[2]), .running(rn[2]), .expired(ex[2]));
  countdown_timer_bcd #(.TICKS_PER_SEC(2), .START_MIN(99), .START_SEC(59)) u3 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .reload(reload),
    .min_tens(mt[3]), .min_ones(mo[3]), .sec_tens(st[3]), .sec_ones(so[3]),
    .sec_tick(tk[3]), .running(rn[3]), .expired(ex[3]));

  function automatic logic [18:0] actual_of(int i);
    return {mt[i], mo[i], st[i], so[i], tk[i], rn[i], ex[i]};
  endfunction

  function automatic logic [18:0] expect_of(int i);
    int m, s;
    m = m_secs[i] / 60;
    s = m_secs[i] % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            m_tick[i], (m_mode[i] == M_RUN), (m_mode[i] == M_EXP)};
  endfunction

  task automatic model_step(int i);
    bit go, hold;
    go   = start && !pause;
    hold = pause && !start;
    if (rst || reload) begin
      m_secs[i] = pre[i]; m_mode[i] = M_IDLE; m_cnt[i] = 0; m_tick[i] = 0;
    end else begin
      m_tick[i] = 0;
      case (m_mode[i])
        M_IDLE:
          if (go) begin
            m_cnt[i]  = 0;
            m_mode[i] = (m_secs[i] == 0) ? M_EXP : M_RUN;
          end
        M_RUN:
          if (hold) m_mode[i] = M_PAUSED;
          else if (m_cnt[i] == tps[i] - 1) begin
            m_cnt[i]  = 0;
            m_secs[i] = m_secs[i] - 1;
            m_tick[i] = 1;
            if (m_secs[i] == 0) m_mode[i] = M_EXP;
          end else m_cnt[i] = m_cnt[i] + 1;
        M_PAUSED: if (go) m_mode[i] = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic check(string name, logic [18:0] act, logic [18:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got digits=%h tick/run/exp=%b required digits=%h tick/run/exp=%b",
               name, act[18:3], act[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i);
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("model_u%0d", i), actual_of(i), expect_of(i));
  endtask

  task automatic drive(bit r, bit s, bit p, bit l);
    rst = r; start = s; pause = p; reload = l;
  endtask

  typedef struct {
    bit          r, s, p, l;
    int unsigned n;
    logic [15:0] dig;
    bit          tick, run, exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 0, 0, 0);

    // Directed table for the 01:30, 4-cycle-per-second instance.
    tbl.push_back('{1, 0, 0, 0,   2, 16'h0130, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0,   1, 16'h0130, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0,   3, 16'h0130, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0,   1, 16'h0129, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0,   2, 16'h0129, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 0,  10, 16'h0129, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0,   1, 16'h0129, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0,   1, 16'h0129, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0,   1, 16'h0128, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 116, 16'h0059, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0,   1, 16'h0059, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 1,   1, 16'h0130, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,   2, 16'h0130, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0,   1, 16'h0130, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0,   3, 16'h0130, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 1,   1, 16'h0130, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,   4, 16'h0130, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0,   1, 16'h0130, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0,   3, 16'h0130, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 0,   1, 16'h0130, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0,   1, 16'h0130, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0,   1, 16'h0129, 1, 1, 0});
    tbl.push_back('{0, 1, 1, 0,   1, 16'h0129, 0, 1, 0});

    foreach (tbl[v]) begin
      drive(tbl[v].r, tbl[v].s, tbl[v].p, tbl[v].l);
      for (int unsigned c = 0; c < tbl[v].n; c++) step();
      check($sformatf("table_row%0d", v), actual_of(0),
            {tbl[v].dig, tbl[v].tick, tbl[v].run, tbl[v].exp});
    end

    // Expiry, zero preset and 99:59 preset sequences, start held throughout.
    drive(1, 0, 0, 0);
    step();
    drive(0, 1, 0, 0);
    for (int k = 1; k <= 121; k++) begin
      step();
      if (k == 1)   check("zero_preset_expires", actual_of(2), {16'h0000, 1'b0, 1'b0, 1'b1});
      if (k == 3)   check("u3_first_tick",       actual_of(3), {16'h9958, 1'b1, 1'b1, 1'b0});
      if (k == 5)   check("u1_at_0001",          actual_of(1), {16'h0001, 1'b1, 1'b1, 1'b0});
      if (k == 9)   check("u1_expiry",           actual_of(1), {16'h0000, 1'b1, 1'b0, 1'b1});
      if (k == 29)  check("u1_expired_hold",     actual_of(1), {16'h0000, 1'b0, 1'b0, 1'b1});
      if (k == 119) check("u3_at_9900",          actual_of(3), {16'h9900, 1'b1, 1'b1, 1'b0});
      if (k == 121) check("u3_min_borrow",       actual_of(3), {16'h9859, 1'b1, 1'b1, 1'b0});
    end
    drive(0, 0, 0, 1);
    step();
    check("u1_reload_from_expired", actual_of(1), {16'h0002, 1'b0, 1'b0, 1'b0});
    drive(0, 0, 0, 0);
    step();

    // Randomised control activity against the model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 2,
            $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
